// File: rtl/pooling_stream_kxk_if.sv
// ----------------------------------------------------------------------------
// pooling_stream_kxk_if
// Stream bundle for the KxK pooling block: input pixel channel, pooled output
// channel and the per-frame mode select.
//   mode       0 = max, 1 = average (taken on the first pixel of a frame)
//   in_valid   / in_ready  / in_data              input pixel handshake
//   out_valid  / out_ready / out_data / out_last  pooled output handshake
// Modports:
//   master  producer/consumer side (drives pixels, mode and out_ready)
//   slave   pooling block side
// ----------------------------------------------------------------------------
interface pooling_stream_kxk_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] out_data;
  logic                 out_last;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pooling_stream_kxk.sv
// ----------------------------------------------------------------------------
// pooling_stream_kxk
// Streaming KxK / stride-K pooling over one IMG_H x IMG_W raster-order map.
// Horizontal partial results are kept in r_hacc; per-window-column vertical
// partials live in a line buffer of IMG_W/K entries. A window's result is
// registered one cycle after its last pixel is accepted, held until taken.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    pooling_stream_kxk_if.slave (mode, in_*, out_* handshakes)
// ----------------------------------------------------------------------------
module pooling_stream_kxk #(
  parameter int BIT_WIDTH = 32,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int K         = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pooling_stream_kxk_if.slave  bus
);

  localparam int LOGK  = $clog2(K);
  localparam int ACC_W = BIT_WIDTH + 2 * LOGK;   // holds a sum of K*K samples
  localparam int NB    = IMG_W / K;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int IW    = (NB > 1) ? $clog2(NB) : 1;

  // Max (signed, ties keep either) or sum, depending on the frame mode.
  function automatic logic signed [ACC_W-1:0] combine(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b,
    input logic                    avg
  );
    if (avg) begin
      return a + b;
    end else if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_row;
  logic                    r_mode;
  logic signed [ACC_W-1:0] r_hacc;
  logic signed [ACC_W-1:0] r_lbuf [NB];
  logic                    r_out_valid;
  logic [BIT_WIDTH-1:0]    r_out_data;
  logic                    r_out_last;

  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_mode;
  logic                    w_first_col;
  logic                    w_last_col;
  logic                    w_first_row;
  logic                    w_last_row;
  logic                    w_win_done;
  logic [IW-1:0]           w_idx;
  logic signed [ACC_W-1:0] w_pix;
  logic signed [ACC_W-1:0] w_h;
  logic signed [ACC_W-1:0] w_v;
  logic [BIT_WIDTH-1:0]    w_result;

  assign w_in_ready    = !r_out_valid || bus.out_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_first_col = (r_col[LOGK-1:0] == {LOGK{1'b0}});
  assign w_last_col  = (r_col[LOGK-1:0] == {LOGK{1'b1}});
  assign w_first_row = (r_row[LOGK-1:0] == {LOGK{1'b0}});
  assign w_last_row  = (r_row[LOGK-1:0] == {LOGK{1'b1}});
  assign w_idx       = IW'(r_col >> LOGK);
  assign w_pix       = {{(2 * LOGK){bus.in_data[BIT_WIDTH-1]}}, bus.in_data};
  assign w_win_done  = w_accept && w_last_col && w_last_row;

  // Datapath: effective mode, horizontal and vertical combine, output value.
  always_comb begin
    w_mode   = r_mode;
    w_h      = w_pix;
    w_v      = w_h;
    w_result = {BIT_WIDTH{1'b0}};
    // The frame's first pixel already has to use the mode being latched with it.
    if ((r_row == {RW{1'b0}}) && (r_col == {CW{1'b0}})) begin
      w_mode = bus.mode;
    end else begin
      w_mode = r_mode;
    end
    if (w_first_col) begin
      w_h = w_pix;
    end else begin
      w_h = combine(r_hacc, w_pix, w_mode);
    end
    if (w_first_row) begin
      w_v = w_h;
    end else begin
      w_v = combine(r_lbuf[w_idx], w_h, w_mode);
    end
    // Arithmetic shift gives floor division of the window sum.
    if (w_mode) begin
      w_result = BIT_WIDTH'(w_v >>> (2 * LOGK));
    end else begin
      w_result = BIT_WIDTH'(w_v);
    end
  end

  // Raster counters, horizontal accumulator and per-frame mode latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col  <= {CW{1'b0}};
      r_row  <= {RW{1'b0}};
      r_mode <= 1'b0;
      r_hacc <= {ACC_W{1'b0}};
    end else if (w_accept) begin
      r_hacc <= w_h;
      r_mode <= w_mode;
      if (r_col == CW'(IMG_W - 1)) begin
        r_col <= {CW{1'b0}};
        if (r_row == RW'(IMG_H - 1)) begin
          r_row <= {RW{1'b0}};
        end else begin
          r_row <= r_row + RW'(1);
        end
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Line buffer of vertical partials; entries are rewritten at window row 0,
  // so they need no reset.
  always_ff @(posedge clk) begin
    if (w_accept && w_last_col) begin
      r_lbuf[w_idx] <= w_v;
    end
  end

  // One-deep output register; a completing window reloads it in the same cycle
  // it is taken, giving full throughput.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {BIT_WIDTH{1'b0}};
      r_out_last  <= 1'b0;
    end else if (w_win_done) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_last  <= (r_col == CW'(IMG_W - 1)) && (r_row == RW'(IMG_H - 1));
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pooling_stream_kxk.sv
module tb_pooling_stream_kxk;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tb_in_valid;
  logic        tb_mode;
  logic        tb_out_ready;
  logic [31:0] tb_in_data;
  logic        sel;          // 0: K=2 4x4 instance, 1: K=4 8x8 instance

  always #5 clk = ~clk;

  pooling_stream_kxk_if #(.BIT_WIDTH(32)) if_a ();
  pooling_stream_kxk_if #(.BIT_WIDTH(32)) if_b ();

  assign if_a.in_valid  = tb_in_valid & ~sel;
  assign if_a.in_data   = tb_in_data;
  assign if_a.mode      = tb_mode;
  assign if_a.out_ready = tb_out_ready;
  assign if_b.in_valid  = tb_in_valid & sel;
  assign if_b.in_data   = tb_in_data;
  assign if_b.mode      = tb_mode;
  assign if_b.out_ready = tb_out_ready;

  pooling_stream_kxk #(.BIT_WIDTH(32), .IMG_W(4), .IMG_H(4), .K(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  pooling_stream_kxk #(.BIT_WIDTH(32), .IMG_W(8), .IMG_H(8), .K(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));

  logic        obs_in_ready, obs_out_valid, obs_out_last;
  logic [31:0] obs_out_data;
  assign obs_in_ready  = sel ? if_b.in_ready  : if_a.in_ready;
  assign obs_out_valid = sel ? if_b.out_valid : if_a.out_valid;
  assign obs_out_data  = sel ? if_b.out_data  : if_a.out_data;
  assign obs_out_last  = sel ? if_b.out_last  : if_a.out_last;

  int n_checks = 0;
  int n_errors = 0;

  int pix_q  [$];
  bit mode_tq[$];
  int exp_d  [$];
  bit exp_l  [$];

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: pool one frame straight from the pixel array.
  task automatic model_frame(input int k, input int w, input int h, input bit m, input int base);
    int sh;
    sh = 2 * $clog2(k);
    for (int wr = 0; wr < h / k; wr++) begin
      for (int wc = 0; wc < w / k; wc++) begin
        longint acc;
        int     mx;
        acc = 0;
        mx  = pix_q[base + wr * k * w + wc * k];
        for (int dy = 0; dy < k; dy++) begin
          for (int dx = 0; dx < k; dx++) begin
            int v;
            v   = pix_q[base + (wr * k + dy) * w + wc * k + dx];
            acc = acc + v;
            if (v > mx) mx = v;
          end
        end
        exp_d.push_back(m ? int'(acc >>> sh) : mx);
        exp_l.push_back((wr == h / k - 1) && (wc == w / k - 1));
      end
    end
  endtask

  task automatic push_frame16(input int arr [16], input bit m);
    for (int i = 0; i < 16; i++) begin
      pix_q.push_back(arr[i]);
      mode_tq.push_back(m);
    end
  endtask

  task automatic push_exp4(input int a, input int b, input int c, input int d);
    exp_d.push_back(a); exp_l.push_back(1'b0);
    exp_d.push_back(b); exp_l.push_back(1'b0);
    exp_d.push_back(c); exp_l.push_back(1'b0);
    exp_d.push_back(d); exp_l.push_back(1'b1);
  endtask

  // Drive the queued pixels and check every pooled output against exp_d/exp_l.
  task automatic run_stream(input int in_gap, input int out_gap, input bit stall_first, input int budget);
    int pi         = 0;
    int outs       = 0;
    int exp_n      = exp_d.size();
    int stall_left = 0;
    bit stalled    = 1'b0;
    bit held       = 1'b0;
    int held_data  = 0;
    int cyc        = 0;
    while ((pi < pix_q.size() || exp_d.size() > 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      tb_in_valid = (pi < pix_q.size()) && ($urandom_range(99) >= in_gap);
      if (pi < pix_q.size()) begin
        tb_in_data = pix_q[pi];
        tb_mode    = mode_tq[pi];
      end
      if (stall_first && !stalled && obs_out_valid) begin
        stalled    = 1'b1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        tb_out_ready = 1'b0;
        stall_left--;
      end else begin
        tb_out_ready = ($urandom_range(99) >= out_gap);
      end
      #1;
      if (held) begin
        check_eq("hold_valid", obs_out_valid, 1);
        check_eq("hold_data", $signed(obs_out_data), held_data);
      end
      if (obs_out_valid && !tb_out_ready) check_eq("in_ready_stall", obs_in_ready, 0);
      if (obs_out_valid && tb_out_ready) begin
        if (exp_d.size() == 0) begin
          check_eq("extra_out", obs_out_valid, 0);
        end else begin
          check_eq("data", $signed(obs_out_data), exp_d.pop_front());
          check_eq("last", obs_out_last, exp_l.pop_front());
          outs++;
        end
      end
      held      = obs_out_valid && !tb_out_ready;
      held_data = obs_out_data;
      if (tb_in_valid && obs_in_ready) pi++;
    end
    check_eq("pixels_sent", pi, pix_q.size());
    check_eq("out_count", outs, exp_n);
    if (stall_first) check_eq("stall_seen", stalled, 1);
    @(negedge clk);
    tb_in_valid  = 1'b0;
    tb_out_ready = 1'b1;
    pix_q.delete(); mode_tq.delete(); exp_d.delete(); exp_l.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_out_valid"}, obs_out_valid, 0);
    check_eq({tag, "_out_last"}, obs_out_last, 0);
    check_eq({tag, "_out_data"}, obs_out_data, 0);
    check_eq({tag, "_in_ready"}, obs_in_ready, 1);
  endtask

  initial begin
    int ramp [16];
    int neg_avg [16];
    int neg_max [16];
    for (int i = 0; i < 16; i++) begin
      ramp[i]    = i;
      neg_avg[i] = 0;
      neg_max[i] = 0;
    end
    neg_avg[0] = -1; neg_avg[1] = -2; neg_avg[4] = -2; neg_avg[5] = -2;
    neg_max[0] = -8; neg_max[1] = -3; neg_max[4] = -5; neg_max[5] = -9;

    rst_n = 1'b0; tb_in_valid = 1'b0; tb_mode = 1'b0; tb_out_ready = 1'b1;
    tb_in_data = 32'd0; sel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("rst_a");
    sel = 1'b1; #1;
    check_reset_state("rst_b");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 1: max over ramp
    push_frame16(ramp, 1'b0); push_exp4(5, 7, 13, 15);
    run_stream(0, 0, 1'b0, 200);
    // 2: average over ramp (floors x.5)
    push_frame16(ramp, 1'b1); push_exp4(2, 4, 10, 12);
    run_stream(0, 0, 1'b0, 200);
    // 3: negative windows
    push_frame16(neg_avg, 1'b1); push_exp4(-2, 0, 0, 0);
    push_frame16(neg_max, 1'b0); push_exp4(-3, 0, 0, 0);
    run_stream(0, 0, 1'b0, 200);
    // 4: consumer stall of 5 cycles
    push_frame16(ramp, 1'b0); push_exp4(5, 7, 13, 15);
    run_stream(0, 0, 1'b1, 200);
    // K=2 random frames with gaps
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) begin
        pix_q.push_back(int'($urandom_range(2000)) - 1000);
        mode_tq.push_back(f[0]);
      end
      model_frame(2, 4, 4, f[0], f * 16);
    end
    run_stream(25, 25, 1'b0, 2000);

    // 5: K=4 8x8, two frames, mode toggled mid-frame 1
    sel = 1'b1;
    for (int m0 = 0; m0 < 2; m0++) begin
      for (int i = 0; i < 128; i++) begin
        pix_q.push_back(int'($urandom));
        if (i < 20) mode_tq.push_back(m0[0]);
        else        mode_tq.push_back(!m0[0]);
      end
      model_frame(4, 8, 8, m0[0], 0);
      model_frame(4, 8, 8, !m0[0], 64);
      run_stream(30, 30, 1'b0, 5000);
    end
    sel = 1'b0;

    // 6: reset after 6 pixels, then a fresh frame
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tb_in_valid = 1'b1; tb_in_data = i; tb_mode = 1'b0; tb_out_ready = 1'b0;
    end
    @(negedge clk);
    tb_in_valid = 1'b0;
    #1;
    check_eq("pre_reset_valid", obs_out_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_state("midrst");
    rst_n = 1'b1;
    tb_out_ready = 1'b1;
    push_frame16(ramp, 1'b0); push_exp4(5, 7, 13, 15);
    run_stream(0, 0, 1'b0, 200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
